// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types used by the fetch path.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One instruction-buffer slot: the byte address and the word fetched from it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction buffer with synchronous reset and flush.
// Flush empties the buffer and suppresses any push/pop in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2 * XLEN,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full_o   = (count_q == CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0) && !flush_i;
    // A push into a full buffer is only legal when the head leaves this cycle.
    do_push  = push_i && (!full_o || do_pop) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-cycle instruction memory port and a
// small buffer toward decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  // Decode handshake: an instruction transfers in every cycle where out_valid
  // and out_ready are both high; while out_valid is high and out_ready low the
  // head is held unchanged. A redirect in the same cycle cancels the transfer.

  logic [31:0]  pc_q, pc_d;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic [CW-1:0] fifo_count;
  logic [63:0]  fifo_rdata;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  // imem_addr comes straight from the register, so neither out_ready nor
  // redirect_valid can reach the memory address combinationally.
  assign imem_addr = word_align(pc_q);

  always_comb begin
    fifo_pop   = !rst && !redirect_valid && out_valid && out_ready;
    fifo_push  = !rst && !redirect_valid && (!fifo_full || fifo_pop);
    push_entry = '{pc: imem_addr, instr: imem_rdata};
    pc_d       = pc_q;
    if (redirect_valid)  pc_d = word_align(redirect_pc);
    else if (fifo_push)  pc_d = imem_addr + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= word_align(RESET_PC);
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign head      = fifo_rdata;
  assign out_valid = (fifo_count != '0);
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head.pc    : 32'h0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte fetch address driven to instruction memory, word-aligned.
REQ-006 SHALL have port imem_rdata, input, 32 bits: instruction word returned combinationally in the same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 SHALL have port out_valid, output, 1 bit: instruction available to decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the instruction.
REQ-011 SHALL have port out_instr, output, 32 bits: instruction at the buffer head.
REQ-012 SHALL have port out_pc, output, 32 bits: byte address of out_instr.

Function
REQ-013 SHALL hold a fetch PC register; imem_addr SHALL equal {pc[31:2],2'b00} every cycle.
REQ-014 SHALL perform a fetch (push {pc, imem_rdata} into the buffer, pc <= pc+4) in any cycle where the buffer is not full, or is full and a pop occurs in the same cycle, and redirect_valid=0.
REQ-015 SHALL pop the buffer head when out_valid=1 and out_ready=1; out_valid SHALL equal (count != 0).
REQ-016 SHALL keep out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive out_instr=32'h0000_0013 (NOP) and out_pc=0 when out_valid=0.
REQ-018 SHALL give a one-cycle latency: an instruction fetched in cycle N is presented with out_valid=1 in cycle N+1.
REQ-019 SHALL, when redirect_valid=1, flush all buffer entries, discard any concurrent push and pop, and load pc <= {redirect_pc[31:2],2'b00}.
REQ-020 SHALL ignore redirect_pc[1:0]; no exception is raised for misalignment.
REQ-021 SHALL, after a redirect in cycle N, fetch the target in cycle N+1 and present it with out_valid=1 in cycle N+2.
REQ-022 SHALL let pc wrap modulo 2^32: pc=32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-023 SHALL never overflow or underflow the buffer; count SHALL stay within 0..DEPTH.
REQ-024 SHALL sustain one instruction per cycle when out_ready is held at 1.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set pc=RESET_PC and count=0 and clear the buffer pointers; rst SHALL take priority over redirect_valid.
REQ-026 SHALL drive out_valid=0, out_instr=NOP and out_pc=0 in the cycle after reset is applied, and SHALL perform no fetch in any cycle where rst=1.
REQ-027 SHALL, when rst is asserted mid-stream, discard buffered instructions; the first fetch after deassertion SHALL be at RESET_PC.

Structure
REQ-028 SHALL take XLEN=32, NOP_INSTR=32'h0000_0013 and the default RESET_PC from a shared package, riscv_pkg.
REQ-029 SHALL implement the buffer as one sub-module, fetch_fifo: parameterised DEPTH and width 64 {pc, instr}, with a synchronous flush input.
REQ-030 SHALL contain no combinational path from out_ready or redirect_valid to imem_addr.

Verification
REQ-031 SHALL show reset: rst held 2 cycles, then released -> imem_addr=0x0 in the first cycle after release, out_valid=1 with out_pc=0x0 one cycle later.
REQ-032 SHALL show streaming: out_ready=1, memory word i = 0x1000+i -> out_instr sequence 0x1000, 0x1001, 0x1002 on consecutive cycles with out_pc 0x0, 0x4, 0x8.
REQ-033 SHALL show backpressure: out_ready=0 for 5 cycles -> exactly 2 fetches, then imem_addr held at 0x8; out_instr stays 0x1000; after release, no instruction is lost or duplicated.
REQ-034 SHALL show redirect: redirect_valid=1 with redirect_pc=0x40 while the buffer is full -> out_valid=0 next cycle, then out_pc=0x40 and out_instr=word 16.
REQ-035 SHALL show misaligned redirect: redirect_pc=0x43 -> imem_addr=0x40.
REQ-036 SHALL show wrap and mid-stream reset: RESET_PC=0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; then rst=1 concurrently with redirect_valid=1 -> restart at RESET_PC.
